// File: rtl/narrow_pkg.sv
// Shared widths, saturation words and beat type for the 32-to-16 narrowing unit.
package narrow_pkg;

    localparam int unsigned IN_W_DEF  = 32;
    localparam int unsigned OUT_W_DEF = 16;
    localparam int unsigned CNT_W_DEF = 16;

    localparam logic [OUT_W_DEF-1:0] SAT_SMAX = 16'h7FFF;
    localparam logic [OUT_W_DEF-1:0] SAT_SMIN = 16'h8000;
    localparam logic [OUT_W_DEF-1:0] SAT_UMAX = 16'hFFFF;

    typedef struct packed {
        logic [IN_W_DEF-1:0] data;
        logic                is_signed;
        logic                fits;
    } beat_t;

endpackage

// File: rtl/narrow_fit_check.sv
// Combinational range check: does the word fit in OUT_W bits as a signed or unsigned value.
module narrow_fit_check
    import narrow_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF
) (
    input  logic [IN_W-OUT_W:0] data_hi,
    input  logic                is_signed,
    output logic                fits,
    output logic                sign
);

    // data_hi is in_data[IN_W-1:OUT_W-1]; bit 0 is the would-be sign bit of the result.
    always_comb begin
        sign = data_hi[IN_W-OUT_W];
        if (is_signed) begin
            fits = (&data_hi) | ~(|data_hi);
        end else begin
            fits = ~(|data_hi[IN_W-OUT_W:1]);
        end
    end

endmodule

// File: rtl/narrow_saturate_unit.sv
// Two-stage 32-to-16 narrowing pipeline with overflow flag, sticky bit and event counter.
// Define NARROW_SATURATE_EN to saturate overflowing beats; otherwise they truncate.
module narrow_saturate_unit
    import narrow_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             clr_ovf
);

`ifdef NARROW_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [OUT_W-1:0] SMAX = (OUT_W == OUT_W_DEF) ? SAT_SMAX : {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SMIN = (OUT_W == OUT_W_DEF) ? SAT_SMIN : {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] UMAX = (OUT_W == OUT_W_DEF) ? SAT_UMAX : {OUT_W{1'b1}};

    logic             fit_ok;
    logic             fit_sign;
    logic             s1_valid;
    logic [OUT_W-1:0] s1_data;
    logic             s1_signed;
    logic             s1_sign;
    logic             s1_fits;
    logic             s1_adv;
    logic [OUT_W-1:0] sat_word;
    logic [OUT_W-1:0] s2_data_next;
    logic             ovf_event;

    narrow_fit_check #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_fit (
        .data_hi   (in_data[IN_W-1:OUT_W-1]),
        .is_signed (in_signed),
        .fits      (fit_ok),
        .sign      (fit_sign)
    );

    assign s1_adv    = !out_valid || out_ready;
    assign in_ready  = !s1_valid || s1_adv;
    assign ovf_event = out_valid && out_ready && out_ovf;

    always_comb begin
        sat_word     = s1_signed ? (s1_sign ? SMIN : SMAX) : UMAX;
        s2_data_next = (!s1_fits && SAT_EN) ? sat_word : s1_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_signed <= 1'b0;
            s1_sign   <= 1'b0;
            s1_fits   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_data   <= in_data[OUT_W-1:0];
                    s1_signed <= in_signed;
                    s1_sign   <= fit_sign;
                    s1_fits   <= fit_ok;
                end
            end
            // S2 only loads a real beat, so out_data/out_ovf hold while stalled or idle.
            if (s1_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= s2_data_next;
                    out_ovf  <= !s1_fits;
                end
            end
        end
    end

    // A clear coincident with an event leaves the event counted as the first one.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end else if (clr_ovf) begin
            ovf_sticky <= ovf_event;
            ovf_count  <= CNT_W'(ovf_event);
        end else if (ovf_event) begin
            ovf_sticky <= 1'b1;
            if (!(&ovf_count)) begin
                ovf_count <= ovf_count + 1'b1;
            end
        end
    end

endmodule
